// File: rtl/mu_partition_core_pkg.sv
// Shared constants for the partition core: opcodes, instruction fields,
// FSM state encoding and the xorshift parameters used by the state hash.
package mu_partition_core_pkg;

    localparam logic [7:0] OP_PNEW     = 8'h00;
    localparam logic [7:0] OP_XOR_LOAD = 8'h0A;
    localparam logic [7:0] OP_XOR_ADD  = 8'h0B;
    localparam logic [7:0] OP_XOR_SWAP = 8'h0C;
    localparam logic [7:0] OP_EMIT     = 8'h0E;
    localparam logic [7:0] OP_HALT     = 8'hFF;

    localparam int unsigned OPC_LSB = 24;
    localparam int unsigned A_LSB   = 16;
    localparam int unsigned B_LSB   = 8;

    localparam int unsigned HASH_WORDS = 8;
    localparam int unsigned SHIFT_A    = 13;
    localparam int unsigned SHIFT_B    = 17;
    localparam int unsigned SHIFT_C    = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEMWAIT,
        S_SEARCH,
        S_HASH,
        S_DONE,
        S_TIMEOUT
    } state_t;

endpackage

// File: rtl/mu_partition_core_mu_hash_mix.sv
// Combinational 32-bit xorshift step applied to each pre-mix word in HASH.
module mu_hash_mix
    import mu_partition_core_pkg::*;
(
    input  logic [31:0] x_in,
    output logic [31:0] x_out
);

    logic [31:0] s1;
    logic [31:0] s2;

    always_comb begin
        s1    = x_in ^ (x_in << SHIFT_A);
        s2    = s1 ^ (s1 >> SHIFT_B);
        x_out = s2 ^ (s2 << SHIFT_C);
    end

endmodule

// File: rtl/mu_partition_core.sv
// Partition-table executor: fetches instructions, tracks discovered modules
// and mu cost, and emits a 256-bit state hash on HALT.
module mu_partition_core
    import mu_partition_core_pkg::*;
#(
    parameter int unsigned REGION_W    = 64,
    parameter int unsigned MAX_MODULES = 64,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned PC_W        = 8,
    parameter int unsigned MAX_STEPS   = 10000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr_data,
    output logic [PC_W-1:0] pc,
    output logic            mem_rd_en,
    output logic [7:0]      mem_rd_addr,
    input  logic [31:0]     mem_rd_data,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic            illegal_seen,
    output logic            table_full,
    output logic [31:0]     num_modules,
    output logic [31:0]     step_count,
    output logic [63:0]     mu_discovery,
    output logic [63:0]     mu_execution,
    output logic [63:0]     mu_total,
    output logic [255:0]    final_hash
);

    localparam int unsigned MIDX_W = (MAX_MODULES > 1) ? $clog2(MAX_MODULES) : 1;
    localparam int unsigned RIDX_W = $clog2(NUM_REGS);

    state_t state_q, state_d;

    logic [REGION_W-1:0] table_q [MAX_MODULES];
    logic [31:0]         regs_q  [NUM_REGS];
    logic [31:0]         next_id_q;
    logic [MIDX_W-1:0]   search_idx_q;
    logic [REGION_W-1:0] search_mask_q;
    logic [8:0]          search_pop_q;
    logic                found_q;
    logic [RIDX_W-1:0]   dest_q;
    logic [2:0]          hash_idx_q;

    logic [7:0]          opcode, op_a, op_b;
    logic [RIDX_W-1:0]   ra, rb;
    logic                step_limit, accept, pnew_legal, search_last, search_hit, retire;
    logic [31:0]         pnew_top;
    logic [REGION_W-1:0] ones, new_mask;
    logic [31:0]         hash_word, mix_out;
    logic                unused_bits;

    assign opcode      = instr_data[OPC_LSB +: 8];
    assign op_a        = instr_data[A_LSB +: 8];
    assign op_b        = instr_data[B_LSB +: 8];
    assign unused_bits = ^instr_data[7:0];
    assign ra          = op_a[RIDX_W-1:0];
    assign rb          = op_b[RIDX_W-1:0];

    assign step_limit  = (step_count == 32'(MAX_STEPS));
    assign accept      = (state_q == S_FETCH) && instr_valid && !step_limit;
    assign pnew_top    = 32'(op_a) + 32'(op_b) + 32'd1;
    assign pnew_legal  = (pnew_top <= 32'(REGION_W));
    assign ones        = '1;
    // Elements a..a+b: ones from bit a upward, minus ones from bit a+b+1 upward.
    assign new_mask    = (ones << op_a) & ~(ones << pnew_top);
    assign search_last = (32'(search_idx_q) == num_modules - 32'd1);
    assign search_hit  = (table_q[search_idx_q] == search_mask_q);

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_TIMEOUT);
    assign done         = (state_q == S_DONE);
    assign timeout      = (state_q == S_TIMEOUT);
    assign mu_execution = '0;

    always_comb begin
        retire = 1'b0;
        if (accept) begin
            unique case (opcode)
                OP_XOR_LOAD, OP_HALT: retire = 1'b0;
                OP_PNEW:              retire = !pnew_legal;
                default:              retire = 1'b1;
            endcase
        end else if (state_q == S_MEMWAIT) begin
            retire = 1'b1;
        end else if (state_q == S_SEARCH) begin
            retire = search_last;
        end
    end

    always_comb begin
        unique case (hash_idx_q)
            3'd0:    hash_word = 32'(pc) ^ next_id_q;
            3'd1:    hash_word = num_modules ^ step_count;
            3'd2:    hash_word = mu_discovery[31:0] ^ mu_execution[31:0];
            3'd3:    hash_word = mu_discovery[31:0] + mu_execution[31:0];
            3'd4:    hash_word = table_q[0][31:0];
            3'd5:    hash_word = (num_modules > 32'd1) ? table_q[1][31:0] : '0;
            3'd6:    hash_word = regs_q[0];
            default: hash_word = regs_q[1];
        endcase
    end

    mu_hash_mix u_mix (
        .x_in  (hash_word),
        .x_out (mix_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        unique case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (step_limit) begin
                    state_d = S_TIMEOUT;
                end else begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        if (opcode == OP_XOR_LOAD) begin
                            mem_rd_en   = 1'b1;
                            mem_rd_addr = op_b;
                            state_d     = S_MEMWAIT;
                        end else if (opcode == OP_PNEW && pnew_legal) begin
                            state_d = S_SEARCH;
                        end else if (opcode == OP_HALT) begin
                            state_d = S_HASH;
                        end
                    end
                end
            end
            S_MEMWAIT: state_d = S_FETCH;
            S_SEARCH:  if (search_last) state_d = S_FETCH;
            S_HASH:    if (hash_idx_q == 3'(HASH_WORDS - 1)) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (!busy && start)) begin
            for (int unsigned i = 0; i < MAX_MODULES; i++) table_q[i] <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pc            <= '0;
            step_count    <= '0;
            mu_total      <= '0;
            final_hash    <= '0;
            illegal_seen  <= 1'b0;
            table_full    <= 1'b0;
            search_idx_q  <= '0;
            search_mask_q <= '0;
            search_pop_q  <= '0;
            found_q       <= 1'b0;
            dest_q        <= '0;
            hash_idx_q    <= '0;
            if (rst) begin
                num_modules  <= '0;
                next_id_q    <= '0;
                mu_discovery <= '0;
            end else begin
                table_q[0]   <= REGION_W'(1);
                num_modules  <= 32'd1;
                next_id_q    <= 32'd1;
                mu_discovery <= 64'd1;
            end
        end else begin
            if (retire) begin
                pc         <= pc + 1'b1;
                step_count <= step_count + 32'd1;
            end
            if (accept) begin
                unique case (opcode)
                    OP_PNEW: begin
                        if (pnew_legal) begin
                            search_mask_q <= new_mask;
                            search_pop_q  <= 9'(op_b) + 9'd1;
                            search_idx_q  <= '0;
                            found_q       <= 1'b0;
                        end else begin
                            illegal_seen <= 1'b1;
                        end
                    end
                    OP_XOR_LOAD: dest_q <= ra;
                    OP_XOR_ADD:  regs_q[ra] <= regs_q[ra] ^ regs_q[rb];
                    OP_XOR_SWAP: begin
                        regs_q[ra] <= regs_q[rb];
                        regs_q[rb] <= regs_q[ra];
                    end
                    OP_EMIT:     ;
                    OP_HALT:     hash_idx_q <= '0;
                    default:     illegal_seen <= 1'b1;
                endcase
            end
            if (state_q == S_MEMWAIT) regs_q[dest_q] <= mem_rd_data;
            if (state_q == S_SEARCH) begin
                search_idx_q <= search_idx_q + 1'b1;
                if (search_hit) found_q <= 1'b1;
                // The whole table is always scanned; insert only after the last compare.
                if (search_last && !found_q && !search_hit) begin
                    if (num_modules < 32'(MAX_MODULES)) begin
                        table_q[num_modules[MIDX_W-1:0]] <= search_mask_q;
                        num_modules  <= num_modules + 32'd1;
                        next_id_q    <= next_id_q + 32'd1;
                        mu_discovery <= mu_discovery + 64'(search_pop_q);
                    end else begin
                        table_full <= 1'b1;
                    end
                end
            end
            if (state_q == S_HASH) begin
                final_hash[{hash_idx_q, 5'd0} +: 32] <= mix_out;
                hash_idx_q <= hash_idx_q + 3'd1;
                if (hash_idx_q == 3'(HASH_WORDS - 1)) mu_total <= mu_discovery + mu_execution;
            end
        end
    end

endmodule

// File: tb/tb_mu_partition_core.sv
// Scoreboard bench: a behavioural program interpreter predicts run results
// and per-instruction latencies; a monitor checks them as the DUT reports.
module tb_mu_partition_core;
    import mu_partition_core_pkg::*;

    localparam int unsigned RW   = 64;
    localparam int unsigned MAXM = 4;
    localparam int unsigned MAXS = 16;

    logic         clk = 1'b0;
    logic         rst, start, instr_valid, instr_ready, mem_rd_en;
    logic [31:0]  instr_data, mem_rd_data;
    logic [7:0]   pc, mem_rd_addr;
    logic         busy, done, timeout, illegal_seen, table_full;
    logic [31:0]  num_modules, step_count;
    logic [63:0]  mu_discovery, mu_execution, mu_total;
    logic [255:0] final_hash;

    always #5 clk = ~clk;

    mu_partition_core #(.REGION_W(RW), .MAX_MODULES(MAXM), .NUM_REGS(32), .PC_W(8), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .pc(pc), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .busy(busy), .done(done), .timeout(timeout),
        .illegal_seen(illegal_seen), .table_full(table_full), .num_modules(num_modules),
        .step_count(step_count), .mu_discovery(mu_discovery), .mu_execution(mu_execution),
        .mu_total(mu_total), .final_hash(final_hash)
    );

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    bit          valid_en = 1'b0;

    // Invalid cycles present a HALT so a core that ignores valid goes astray.
    assign instr_data = instr_valid ? imem[pc] : 32'hFF00_0000;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= dmem[mem_rd_addr];
        else           mem_rd_data <= $urandom;
    end

    initial begin
        instr_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            instr_valid = valid_en && ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        logic         timed_out;
        logic [7:0]   pc;
        logic [31:0]  nmods;
        logic [31:0]  steps;
        logic [63:0]  mu;
        logic         illegal;
        logic         full;
        logic [255:0] hash;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   halt_seen = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b, 8'($urandom)};
    endfunction

    // Interprets imem/dmem as a program; pushes each retired instruction's latency.
    task automatic model_run(output exp_t e);
        logic [63:0] mods[$];
        logic [31:0] regs [32];
        logic [31:0] w [8];
        logic [31:0] ins;
        logic [63:0] m, mu;
        logic [7:0]  p, op, a, b;
        int          steps, lat, bb;
        bit          ill, full, to, found;
        logic [31:0] t;
        mods = {};
        mods.push_back(64'd1);
        for (int i = 0; i < 32; i++) regs[i] = '0;
        p = '0; steps = 0; mu = 64'd1; ill = 0; full = 0; to = 0;
        while (1) begin
            if (steps == int'(MAXS)) begin to = 1; break; end
            ins = imem[p];
            op = ins[31:24]; a = ins[23:16]; b = ins[15:8];
            if (op == OP_HALT) break;
            lat = 1;
            case (op)
                OP_PNEW: begin
                    if (int'(a) + int'(b) >= int'(RW)) ill = 1;
                    else begin
                        bb = int'(b);
                        m = ((bb + 1 >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (bb + 1)) - 64'd1)) << a;
                        lat = mods.size() + 1;
                        found = 0;
                        foreach (mods[k]) if (mods[k] == m) found = 1;
                        if (!found) begin
                            if (mods.size() < int'(MAXM)) begin mods.push_back(m); mu += 64'(bb + 1); end
                            else full = 1;
                        end
                    end
                end
                OP_XOR_LOAD: begin regs[a[4:0]] = dmem[b]; lat = 2; end
                OP_XOR_ADD:  regs[a[4:0]] = regs[a[4:0]] ^ regs[b[4:0]];
                OP_XOR_SWAP: begin t = regs[a[4:0]]; regs[a[4:0]] = regs[b[4:0]]; regs[b[4:0]] = t; end
                OP_EMIT:     ;
                default:     ill = 1;
            endcase
            lat_q.push_back(lat);
            p++;
            steps++;
        end
        e.timed_out = to; e.pc = p; e.nmods = mods.size(); e.steps = steps;
        e.mu = mu; e.illegal = ill; e.full = full; e.hash = '0;
        if (!to) begin
            w[0] = 32'(p) ^ 32'(mods.size());
            w[1] = 32'(mods.size()) ^ 32'(steps);
            w[2] = mu[31:0];
            w[3] = mu[31:0];
            w[4] = mods[0][31:0];
            w[5] = (mods.size() > 1) ? mods[1][31:0] : 32'd0;
            w[6] = regs[0];
            w[7] = regs[1];
            for (int k = 0; k < 8; k++) e.hash[k*32 +: 32] = xs(w[k]);
        end
    endtask

    // Monitor: latency per retired instruction, HALT-to-done delay, run results.
    exp_t        mon_e;
    bit          reported = 1'b0, lat_open = 1'b0, halt_open = 1'b0;
    int          lat_cnt, lat_exp, halt_cnt;
    logic [31:0] lat_base;

    always @(negedge clk) begin
        if (rst) begin
            lat_open = 0; halt_open = 0; reported = 0;
        end else begin
            if (lat_open) begin
                lat_cnt++;
                if (step_count != lat_base) begin
                    chk("latency", 256'(lat_cnt), 256'(lat_exp));
                    lat_open = 0;
                end else if (lat_cnt > 300) begin
                    chk("latency_bound", 256'(lat_cnt), 256'(lat_exp));
                    lat_open = 0;
                end
            end
            if (halt_open) halt_cnt++;
            if (instr_valid && instr_ready) begin
                if (instr_data[31:24] == OP_HALT) begin
                    halt_open = 1; halt_cnt = 0; halt_seen = 1;
                end else if (lat_q.size() == 0) begin
                    chk("unexpected_accept", 256'(step_count), 256'(32'hFFFF_FFFF));
                end else begin
                    lat_exp = lat_q.pop_front(); lat_open = 1; lat_cnt = 0; lat_base = step_count;
                end
            end
            if ((done || timeout) && !reported) begin
                reported = 1;
                // The HALT accept edge follows the negedge that saw the handshake.
                if (done && halt_open) begin chk("halt_to_done", 256'(halt_cnt), 256'(9)); halt_open = 0; end
                if (exp_q.size() == 0) chk("unexpected_end", 256'(done), 256'(0));
                else begin
                    mon_e = exp_q.pop_front();
                    chk("done", 256'(done), 256'(!mon_e.timed_out));
                    chk("timeout", 256'(timeout), 256'(mon_e.timed_out));
                    chk("pc", 256'(pc), 256'(mon_e.pc));
                    chk("num_modules", 256'(num_modules), 256'(mon_e.nmods));
                    chk("step_count", 256'(step_count), 256'(mon_e.steps));
                    chk("mu_discovery", 256'(mu_discovery), 256'(mon_e.mu));
                    chk("mu_execution", 256'(mu_execution), 256'(0));
                    chk("mu_total", 256'(mu_total), mon_e.timed_out ? 256'(0) : 256'(mon_e.mu));
                    chk("illegal_seen", 256'(illegal_seen), 256'(mon_e.illegal));
                    chk("table_full", 256'(table_full), 256'(mon_e.full));
                    chk("final_hash", final_hash, mon_e.hash);
                end
            end
            if (busy) reported = 0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_pc"}, 256'(pc), 256'(0));
        chk({tag, "_flags"}, 256'({busy, done, timeout, illegal_seen, table_full, instr_ready, mem_rd_en}), 256'(0));
        chk({tag, "_counts"}, 256'({num_modules, step_count}), 256'(0));
        chk({tag, "_mu"}, 256'({mu_discovery, mu_execution, mu_total}), 256'(0));
        chk({tag, "_hash"}, final_hash, 256'(0));
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic run_prog();
        exp_t e;
        int   n;
        model_run(e);
        exp_q.push_back(e);
        pulse_start();
        n = 0;
        while (!(done || timeout) && n < 3000) begin
            start = (n == 2);
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL run_bound: no done/timeout after %0d cycles, expected completion", n);
            void'(exp_q.pop_back());
            lat_q.delete();
            rst = 1'b1; tick(); rst = 1'b0;
        end
        tick(); tick();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = mk(OP_EMIT, 8'($urandom), 8'($urandom));
    endtask

    task automatic gen_random();
        int         len;
        bit         halt;
        logic [7:0] a, b;
        clear_prog();
        for (int i = 0; i < 256; i++) dmem[i] = $urandom;
        len  = $urandom_range(1, 14);
        halt = ($urandom_range(0, 4) != 0);
        for (int i = 0; i < len; i++) begin
            a = 8'($urandom_range(0, 3) + 32 * $urandom_range(0, 7));
            b = 8'($urandom_range(0, 3) + 32 * $urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0, 1: begin
                    a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 80)) : 8'($urandom_range(0, 3));
                    imem[i] = mk(OP_PNEW, a, 8'($urandom_range(0, 2)));
                end
                2:       imem[i] = mk(OP_XOR_LOAD, a, 8'($urandom));
                3:       imem[i] = mk(OP_XOR_ADD, a, b);
                4:       imem[i] = mk(OP_XOR_SWAP, a, b);
                5:       imem[i] = mk(OP_EMIT, a, b);
                default: imem[i] = mk(8'h42, a, b);
            endcase
        end
        if (halt) imem[len] = mk(OP_HALT, 8'd0, 8'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1; start = 1'b0;
        clear_prog();
        for (int i = 0; i < 256; i++) dmem[i] = $urandom;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("reset");
        valid_en = 1'b1;

        clear_prog();
        imem[0] = mk(OP_PNEW, 8'd3, 8'd0);
        imem[1] = mk(OP_HALT, 8'd0, 8'd0);
        run_prog();

        clear_prog();
        imem[0] = mk(OP_PNEW, 8'd3, 8'd2);
        imem[1] = mk(OP_PNEW, 8'd3, 8'd2);
        imem[2] = mk(OP_HALT, 8'd0, 8'd0);
        run_prog();

        clear_prog();
        dmem[5] = 32'hA5; dmem[6] = 32'h0F;
        imem[0] = mk(OP_XOR_LOAD, 8'd1, 8'd5);
        imem[1] = mk(OP_XOR_LOAD, 8'd2, 8'd6);
        imem[2] = mk(OP_XOR_ADD, 8'd1, 8'd2);
        imem[3] = mk(OP_XOR_SWAP, 8'd1, 8'd2);
        imem[4] = mk(OP_HALT, 8'd0, 8'd0);
        run_prog();

        clear_prog();
        for (int i = 0; i < 5; i++) imem[i] = mk(OP_PNEW, 8'(i + 1), 8'd0);
        imem[5] = mk(OP_PNEW, 8'd60, 8'd10);
        imem[6] = mk(OP_HALT, 8'd0, 8'd0);
        run_prog();

        clear_prog();
        run_prog();

        // Abort during HASH, then rerun the same program for a bit-exact hash.
        clear_prog();
        imem[0] = mk(OP_PNEW, 8'd7, 8'd4);
        imem[1] = mk(OP_XOR_LOAD, 8'd0, 8'd9);
        imem[2] = mk(OP_XOR_LOAD, 8'd1, 8'd10);
        imem[3] = mk(OP_HALT, 8'd0, 8'd0);
        model_run(e);
        halt_seen = 1'b0;
        pulse_start();
        n = 0;
        while (!halt_seen && n < 3000) begin tick(); n++; end
        if (!halt_seen) begin
            n_cmp++; n_bad++;
            $display("FAIL halt_bound: HALT not accepted after %0d cycles, expected acceptance", n);
            lat_q.delete();
        end
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset("rst_in_hash");
        run_prog();

        for (int r = 0; r < 30; r++) begin
            gen_random();
            run_prog();
        end

        chk("exp_queue_drained", 256'(exp_q.size()), 256'(0));
        chk("lat_queue_drained", 256'(lat_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
